// File: rtl/dm_mem_pkg.sv
// rtl/dm_mem_pkg.sv - shared constants and state encoding for the block memory responder
//
// Purpose: width defaults, request type codes, responder FSM encoding and
// the beat-index width used by the block memory responder and its storage.
// Ports: none (package).
package dm_mem_pkg;

  localparam int DEF_ADDR_WIDTH  = 32;
  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_BLOCK_WORDS = 4;

  localparam logic TYPE_READ  = 1'b0;
  localparam logic TYPE_WRITE = 1'b1;

  localparam int BEAT_W = $clog2(DEF_BLOCK_WORDS);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT     = 3'd1,
    ST_RD_BURST = 3'd2,
    ST_WR_BURST = 3'd3,
    ST_WR_ACK   = 3'd4,
    ST_DONE     = 3'd5
  } rsp_state_e;

endpackage

// File: rtl/mem_array_sp.sv
// rtl/mem_array_sp.sv - single-port word storage with synchronous write and registered read
//
// Purpose: DATA_WIDTH x 2^MEM_AW backing store. One address serves both
// the write and the read; rdata always reflects the word at the address
// presented before the last rising edge. Contents are never reset.
// Ports:
//   clk    - clock
//   we     - write enable, wdata stored at addr on the rising edge
//   addr   - word address
//   wdata  - write data
//   rdata  - registered read data
module mem_array_sp
  import dm_mem_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MEM_AW     = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [MEM_AW-1:0]     addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [0:(1<<MEM_AW)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/block_mem_responder.sv
// rtl/block_mem_responder.sv - block-burst memory responder below a direct-mapped cache
//
// Purpose: accepts block-aligned read/write requests, returns a whole block
// on reads after RD_LATENCY idle cycles and absorbs a whole block on writes,
// acknowledging with a single valid strobe.
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-low reset
//   l_iaddr  - block-aligned word address of the request
//   l_data   - shared data bus (driven here only on read beats)
//   l_itype  - 0 read, 1 write
//   l_enable - request, held high for the whole transaction
//   l_valid  - read beat valid / write completion strobe
//   l_error  - one-cycle pulse for a rejected misaligned request
module block_mem_responder
  import dm_mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int BLOCK_WORDS = DEF_BLOCK_WORDS,
  parameter int MEM_AW      = 10,
  parameter int RD_LATENCY  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] l_iaddr,
  inout  wire  [DATA_WIDTH-1:0] l_data,
  input  logic                  l_itype,
  input  logic                  l_enable,
  output logic                  l_valid,
  output logic                  l_error
);

  localparam int              BW        = $clog2(BLOCK_WORDS);
  localparam logic [BW-1:0]   LAST_BEAT = BW'(BLOCK_WORDS - 1);
  localparam logic [3:0]      LAT_LAST  = (RD_LATENCY > 0) ? 4'(RD_LATENCY - 1) : 4'd0;

  rsp_state_e              state_q, state_d;
  logic [BW-1:0]           beat_q, beat_d;
  logic [3:0]              wcnt_q, wcnt_d;
  logic [MEM_AW-1:0]       base_q;
  logic                    err_q, err_d;
  logic                    accept;
  logic                    mem_we;
  logic [MEM_AW-1:0]       mem_addr;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    unused_addr;

  // Address bits above the storage depth are deliberately ignored (wrap).
  assign unused_addr = ^l_iaddr[ADDR_WIDTH-1:MEM_AW];

  mem_array_sp #(
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_AW    (MEM_AW)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .addr (mem_addr),
    .wdata(l_data),
    .rdata(rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      wcnt_q  <= '0;
      base_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
      if (accept) begin
        base_q <= l_iaddr[MEM_AW-1:0];
      end
    end
  end

  // The storage read is registered, so the address runs one word ahead of
  // the beat being presented: IDLE/WAIT pre-fetch word 0, beat k fetches k+1.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    wcnt_d   = wcnt_q;
    err_d    = 1'b0;
    accept   = 1'b0;
    mem_we   = 1'b0;
    mem_addr = base_q;
    unique case (state_q)
      ST_IDLE: begin
        mem_addr = l_iaddr[MEM_AW-1:0];
        beat_d   = '0;
        wcnt_d   = '0;
        if (l_enable) begin
          accept = 1'b1;
          if (l_iaddr[BW-1:0] != '0) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else if (l_itype == TYPE_WRITE) begin
            state_d = ST_WR_BURST;
          end else begin
            state_d = (RD_LATENCY == 0) ? ST_RD_BURST : ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!l_enable) begin
          state_d = ST_IDLE;
        end else if (wcnt_q == LAT_LAST) begin
          state_d = ST_RD_BURST;
        end else begin
          wcnt_d = wcnt_q + 4'd1;
        end
      end
      ST_RD_BURST: begin
        mem_addr = base_q + MEM_AW'(beat_q) + MEM_AW'(1);
        if (!l_enable) begin
          state_d = ST_IDLE;
        end else if (beat_q == LAST_BEAT) begin
          state_d = ST_DONE;
        end else begin
          beat_d = beat_q + BW'(1);
        end
      end
      ST_WR_BURST: begin
        mem_addr = base_q + MEM_AW'(beat_q);
        if (!l_enable) begin
          state_d = ST_IDLE;
        end else begin
          mem_we = 1'b1;
          if (beat_q == LAST_BEAT) begin
            state_d = ST_WR_ACK;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      ST_WR_ACK: begin
        state_d = l_enable ? ST_DONE : ST_IDLE;
      end
      ST_DONE: begin
        if (!l_enable) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign l_valid = (state_q == ST_RD_BURST) || (state_q == ST_WR_ACK);
  assign l_error = err_q;
  assign l_data  = (state_q == ST_RD_BURST) ? rdata : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_block_mem_responder.sv
// tb/tb_block_mem_responder.sv - self-checking bench for block_mem_responder
module tb_block_mem_responder;

  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int BWORDS = 4;
  localparam int MAW    = 10;
  localparam int LAT    = 2;
  localparam int DEPTH  = 1 << MAW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] l_iaddr = '0;
  logic          l_itype = 1'b0;
  logic          l_enable = 1'b0;
  wire  [DW-1:0] l_data;
  logic          l_valid;
  logic          l_error;

  // Requester side of the bus: drives zero whenever the responder must be
  // silent, so any responder drive shows up as a non-zero bus value.
  logic          drv_en = 1'b1;
  logic [DW-1:0] drv_data = '0;
  assign l_data = drv_en ? drv_data : {DW{1'bz}};

  always #5 clk = ~clk;

  block_mem_responder #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .BLOCK_WORDS(BWORDS),
    .MEM_AW     (MAW),
    .RD_LATENCY (LAT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .l_iaddr (l_iaddr),
    .l_data  (l_data),
    .l_itype (l_itype),
    .l_enable(l_enable),
    .l_valid (l_valid),
    .l_error (l_error)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model [DEPTH];
  bit            known [DEPTH];
  bit            blk_written [8];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Raises the request for cycle T0; returns at the middle of that cycle.
  task automatic start_req(input logic [AW-1:0] addr, input logic typ);
    next_cycle();
    l_enable = 1'b1;
    l_iaddr  = addr;
    l_itype  = typ;
    drv_en   = 1'b1;
    drv_data = '0;
    @(negedge clk);
  endtask

  task automatic wr_block(input logic [AW-1:0] addr, input logic [BWORDS-1:0][DW-1:0] w,
                          input int n_beats, input string tag);
    int base = int'(addr % DEPTH);
    start_req(addr, 1'b1);
    for (int k = 0; k < BWORDS; k++) begin
      next_cycle();
      l_iaddr = $urandom;
      l_itype = 1'($urandom);
      if (k < n_beats) begin
        drv_data = w[k];
        model[base+k] = w[k];
        known[base+k] = 1'b1;
      end else begin
        l_enable = 1'b0;
        drv_data = '0;
      end
      @(negedge clk);
      chk({tag, " beat valid"}, DW'(l_valid), '0);
    end
    next_cycle();
    drv_data = '0;
    @(negedge clk);
    chk({tag, " ack valid"}, DW'(l_valid), DW'(n_beats == BWORDS));
    chk({tag, " ack bus"}, l_data, '0);
    next_cycle();
    l_enable = 1'b0;
    @(negedge clk);
    chk({tag, " post valid"}, DW'(l_valid), '0);
    next_cycle();
    @(negedge clk);
  endtask

  task automatic rd_block(input logic [AW-1:0] addr, input int hold, input string tag);
    int base = int'(addr % DEPTH);
    start_req(addr, 1'b0);
    for (int c = 1; c <= LAT; c++) begin
      next_cycle();
      l_iaddr = $urandom;
      l_itype = 1'($urandom);
      @(negedge clk);
      chk({tag, " wait valid"}, DW'(l_valid), '0);
      chk({tag, " wait bus"}, l_data, '0);
    end
    for (int k = 0; k < BWORDS; k++) begin
      next_cycle();
      drv_en = 1'b0;
      @(negedge clk);
      chk({tag, " beat valid"}, DW'(l_valid), 32'd1);
      if (known[base+k]) chk({tag, " beat data"}, l_data, model[base+k]);
    end
    next_cycle();
    drv_en   = 1'b1;
    drv_data = '0;
    @(negedge clk);
    chk({tag, " after valid"}, DW'(l_valid), '0);
    chk({tag, " after bus"}, l_data, '0);
    for (int c = 0; c < hold; c++) begin
      next_cycle();
      @(negedge clk);
      chk({tag, " hold valid"}, DW'(l_valid), '0);
    end
    next_cycle();
    l_enable = 1'b0;
    @(negedge clk);
    chk({tag, " release valid"}, DW'(l_valid), '0);
    next_cycle();
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BWORDS-1:0][DW-1:0] w;
    logic [AW-1:0]             addr;
    int                        blk;
    int                        nb;

    // Reset state
    #12;
    chk("reset valid", DW'(l_valid), '0);
    chk("reset error", DW'(l_error), '0);
    chk("reset bus", l_data, '0);
    @(negedge clk);
    rst = 1'b1;

    // Full write then read at 0x40
    w = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    wr_block(32'h40, w, BWORDS, "wr40");
    rd_block(32'h40, 0, "rd40");
    chk("rd40 model word0", model[32'h40], 32'hA0);

    // Misaligned request is rejected and leaves storage untouched
    start_req(32'h41, 1'b0);
    next_cycle();
    @(negedge clk);
    chk("mis error", DW'(l_error), 32'd1);
    chk("mis valid", DW'(l_valid), '0);
    for (int c = 0; c < LAT + BWORDS + 1; c++) begin
      next_cycle();
      @(negedge clk);
      chk("mis hold error", DW'(l_error), '0);
      chk("mis hold valid", DW'(l_valid), '0);
      chk("mis hold bus", l_data, '0);
    end
    next_cycle();
    l_enable = 1'b0;
    @(negedge clk);
    rd_block(32'h40, 0, "rd40 after mis");

    // Address wrap: 0x440 lands on word 0x40
    w = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    wr_block(32'h440, w, BWORDS, "wr440");
    rd_block(32'h40, 0, "rd40 wrapped");

    // Abort after two write beats into a zeroed block
    w = '0;
    wr_block(32'h80, w, BWORDS, "wr80 zero");
    w = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
    wr_block(32'h80, w, 2, "wr80 abort");
    rd_block(32'h80, 8, "rd80 hold");
    chk("abort word2 model", model[32'h82], '0);

    // Reset asserted during the third read beat
    start_req(32'h40, 1'b0);
    for (int c = 1; c <= LAT; c++) begin
      next_cycle();
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      drv_en = 1'b0;
      @(negedge clk);
    end
    chk("rst beat2 valid", DW'(l_valid), 32'd1);
    chk("rst beat2 data", l_data, model[32'h42]);
    #1;
    rst      = 1'b0;
    l_enable = 1'b0;
    drv_en   = 1'b1;
    drv_data = '0;
    #1;
    chk("rst valid drop", DW'(l_valid), '0);
    chk("rst bus release", l_data, '0);
    chk("rst error", DW'(l_error), '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    rd_block(32'h40, 0, "rd40 after rst");

    // Randomised traffic over eight blocks with random upper address bits
    for (int i = 0; i < 24; i++) begin
      blk  = $urandom_range(0, 7);
      addr = AW'(32'h100 + blk * BWORDS) | (AW'($urandom) << MAW);
      if (!blk_written[blk] || ($urandom_range(0, 1) == 1)) begin
        for (int k = 0; k < BWORDS; k++) w[k] = $urandom;
        nb = blk_written[blk] ? $urandom_range(1, BWORDS) : BWORDS;
        wr_block(addr, w, nb, "rnd wr");
        blk_written[blk] = 1'b1;
      end else begin
        rd_block(addr, $urandom_range(0, 3), "rnd rd");
      end
    end
    for (int b = 0; b < 8; b++) begin
      if (blk_written[b]) rd_block(AW'(32'h100 + b * BWORDS), 0, "final rd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
